mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the pipelined MIPS datapath. It is the consumer of the execute-stage latch outputs (PCInc, writeReg, MemtoReg, RWDSel, dREN/dWEN, opcode, result, busB, rw). It issues data-cache requests, holds them until dhit, and stalls the pipeline while a miss is outstanding. It owns the MEM/WB pipeline register that feeds writeback.

Parameters:
STALL_CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, synchronous, active-high
enable  in  1  MEM/WB register load enable from hazard unit
flush  in  1  insert bubble into MEM/WB
writeRegIN, MemtoRegIN, dRENIN, dWENIN, haltIN  in  1 each  control from EX/MEM latch
RWDSelIN  in  2  writeback data select
opcodeIN  in  opcode_t  instruction opcode
PCIncIN, resultIN, busBIN  in  32 each  PC+4, ALU result/address, store data
rwIN  in  5  destination register
dhit  in  1  cache access complete this cycle
dmemload  in  32  cache read data
dmemREN, dmemWEN  out  1 each  cache request
dmemaddr, dmemstore  out  32 each  cache address and store data
writeRegOUT, MemtoRegOUT, haltOUT  out  1 each  MEM/WB control
RWDSelOUT  out  2
opcodeOUT  out  opcode_t
PCIncOUT, resultOUT, loadOUT  out  32 each  MEM/WB data; loadOUT is the captured dmemload
rwOUT  out  5
mem_stall  out  1  freeze IF/ID/EX and EX/MEM latches
stall_cnt  out  STALL_CNT_W  total miss-stall cycles since reset

Behaviour:
- Reset: every output register, including all MEM/WB fields, haltOUT and stall_cnt, goes to 0. FSM goes to IDLE. dmemREN, dmemWEN and mem_stall are 0 in the cycle after reset.
- memop = dRENIN | dWENIN. If both are set, only the read is issued and dmemWEN is forced to 0.
- FSM states: IDLE, WAIT, HALTED.
- IDLE:
  - When memop=1, the request is combinational in the same cycle: dmemREN=dRENIN, dmemWEN=dWENIN&~dRENIN, dmemaddr=resultIN, dmemstore=busBIN.
  - If dhit=1 in that cycle: no stall, MEM/WB loads at the edge, FSM stays in IDLE.
  - If dhit=0: mem_stall=1, next state is WAIT.
  - When memop=0, nothing is requested and MEM/WB loads every enabled cycle (1-cycle pass-through).
- WAIT: the request and its address/data are held, driven from the stalled EX/MEM inputs. mem_stall = ~dhit. On dhit, MEM/WB loads with loadOUT=dmemload and the next state is IDLE. The EX/MEM latch advances on the same edge, so a request is never reissued.
- mem_stall is purely combinational: (state==IDLE & memop & ~dhit) | (state==WAIT & ~dhit).
- MEM/WB load condition: enable & ~mem_stall. When enable=0, the register holds its value and the FSM still runs.
- Flush:
  - In IDLE, when not stalling: MEM/WB control fields (writeRegOUT, MemtoRegOUT, haltOUT latch input) load 0. Data fields are don't-care and load 0.
  - In WAIT, flush is ignored until dhit, because an in-flight store cannot be cancelled. The hazard unit must keep flush asserted if it is still needed.
  - Flush and dhit in the same cycle: the access completes and MEM/WB loads a bubble.
- Halt: haltIN=1 with a MEM/WB load sets haltOUT=1 and moves to HALTED. HALTED is sticky until RST: no cache requests, mem_stall=0, MEM/WB holds.
- stall_cnt increments on every cycle with mem_stall=1. It saturates at all-ones and does not wrap.
- Reset mid-WAIT: the request drops and the FSM goes to IDLE on that edge. No MEM/WB load.

Decomposition:
- Extend cpu_types_pkg with memstate_t (IDLE, WAIT, HALTED) and typedef regbits_t [4:0]. Use the existing opcode_t and word_t.
- Add a mem_if interface with modports mem (stage) and tb. This interface lives alongside the execute interface.
- One sub-module, memwb_reg: the MEM/WB register with enable, flush and sync reset. mem_stage holds the FSM, the request logic and the counter.

Test Plan:
- Reset: hold RST=1 for 2 cycles with arbitrary inputs -> all outputs 0, dmemREN=dmemWEN=0, stall_cnt=0.
- LW hit: dRENIN=1, resultIN=0x100, dhit=1, dmemload=0xDEADBEEF -> same cycle dmemREN=1, dmemaddr=0x100, mem_stall=0. Next edge loadOUT=0xDEADBEEF, rwOUT=rwIN.
- SW miss: dWENIN=1, resultIN=0x200, busBIN=0x1234, dhit low 3 cycles then high -> dmemWEN=1 and dmemstore=0x1234 held 4 cycles; mem_stall=1 for exactly 3 cycles; MEM/WB unchanged until the dhit edge; stall_cnt=3.
- ALU op (memop=0, resultIN=0x55) -> no request; resultOUT=0x55 after 1 edge. With enable=0 the outputs hold prior values.
- Flush: in IDLE -> next edge writeRegOUT=0. Asserted during a WAIT miss -> request held until dhit, then bubble loaded; stall count still correct.
- Halt: haltIN=1 -> haltOUT=1; following dRENIN=1 issues no dmemREN; RST clears haltOUT. RST asserted mid-WAIT -> request drops on the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core.
// Memory-stage additions: memstate_t and regbits_t.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ORI   = 6'h0d,
        LUI   = 6'h0f,
        LW    = 6'h23,
        SW    = 6'h2b,
        HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_if.sv
// Bundle of the memory-stage signals: EX/MEM inputs, cache handshake and
// MEM/WB outputs, with a stage-side and a driver-side view.
interface mem_if
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic                   CLK, RST, enable, flush;
    logic                   writeRegIN, MemtoRegIN, dRENIN, dWENIN, haltIN;
    logic [1:0]             RWDSelIN;
    opcode_t                opcodeIN;
    word_t                  PCIncIN, resultIN, busBIN;
    regbits_t               rwIN;
    logic                   dhit;
    word_t                  dmemload;
    logic                   dmemREN, dmemWEN;
    word_t                  dmemaddr, dmemstore;
    logic                   writeRegOUT, MemtoRegOUT, haltOUT;
    logic [1:0]             RWDSelOUT;
    opcode_t                opcodeOUT;
    word_t                  PCIncOUT, resultOUT, loadOUT;
    regbits_t               rwOUT;
    logic                   mem_stall;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport mem (
        input  CLK, RST, enable, flush, writeRegIN, MemtoRegIN, dRENIN, dWENIN,
               haltIN, RWDSelIN, opcodeIN, PCIncIN, resultIN, busBIN, rwIN,
               dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, writeRegOUT, MemtoRegOUT,
               haltOUT, RWDSelOUT, opcodeOUT, PCIncOUT, resultOUT, loadOUT,
               rwOUT, mem_stall, stall_cnt
    );

    modport tb (
        output CLK, RST, enable, flush, writeRegIN, MemtoRegIN, dRENIN, dWENIN,
               haltIN, RWDSelIN, opcodeIN, PCIncIN, resultIN, busBIN, rwIN,
               dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, writeRegOUT, MemtoRegOUT,
               haltOUT, RWDSelOUT, opcodeOUT, PCIncOUT, resultOUT, loadOUT,
               rwOUT, mem_stall, stall_cnt
    );
endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: loads on i_load, loads an all-zero bubble when
// i_flush accompanies the load, synchronous active-high reset.
module memwb_reg
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      i_load,
    input  logic      i_flush,
    input  logic      i_writeReg,
    input  logic      i_MemtoReg,
    input  logic      i_halt,
    input  logic [1:0] i_RWDSel,
    input  opcode_t   i_opcode,
    input  word_t     i_PCInc,
    input  word_t     i_result,
    input  word_t     i_load_data,
    input  regbits_t  i_rw,
    output logic      o_writeReg,
    output logic      o_MemtoReg,
    output logic      o_halt,
    output logic [1:0] o_RWDSel,
    output opcode_t   o_opcode,
    output word_t     o_PCInc,
    output word_t     o_result,
    output word_t     o_load_data,
    output regbits_t  o_rw
);

    always_ff @(posedge CLK) begin
        if (RST || (i_load && i_flush)) begin
            o_writeReg  <= 1'b0;
            o_MemtoReg  <= 1'b0;
            o_halt      <= 1'b0;
            o_RWDSel    <= '0;
            o_opcode    <= RTYPE;
            o_PCInc     <= '0;
            o_result    <= '0;
            o_load_data <= '0;
            o_rw        <= '0;
        end else if (i_load) begin
            o_writeReg  <= i_writeReg;
            o_MemtoReg  <= i_MemtoReg;
            o_halt      <= i_halt;
            o_RWDSel    <= i_RWDSel;
            o_opcode    <= i_opcode;
            o_PCInc     <= i_PCInc;
            o_result    <= i_result;
            o_load_data <= i_load_data;
            o_rw        <= i_rw;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: issues data-cache requests, stalls the pipeline while a
// miss is outstanding, and feeds the MEM/WB register.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
)(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   writeRegIN,
    input  logic                   MemtoRegIN,
    input  logic                   dRENIN,
    input  logic                   dWENIN,
    input  logic                   haltIN,
    input  logic [1:0]             RWDSelIN,
    input  opcode_t                opcodeIN,
    input  word_t                  PCIncIN,
    input  word_t                  resultIN,
    input  word_t                  busBIN,
    input  regbits_t               rwIN,
    input  logic                   dhit,
    input  word_t                  dmemload,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output word_t                  dmemaddr,
    output word_t                  dmemstore,
    output logic                   writeRegOUT,
    output logic                   MemtoRegOUT,
    output logic                   haltOUT,
    output logic [1:0]             RWDSelOUT,
    output opcode_t                opcodeOUT,
    output word_t                  PCIncOUT,
    output word_t                  resultOUT,
    output word_t                  loadOUT,
    output regbits_t               rwOUT,
    output logic                   mem_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    memstate_t              r_state, w_next;
    logic                   w_memop, w_req, w_stall, w_load;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_memop = dRENIN | dWENIN;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Requests are gated by RST so an outstanding miss drops immediately.
    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                w_req = w_memop;
                if (w_memop && !dhit) begin
                    w_stall = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                w_req   = 1'b1;
                w_stall = ~dhit;
                if (dhit) w_next = IDLE;
            end
            HALTED: ;
            default: w_next = IDLE;
        endcase
        if (RST) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
        w_load = enable & ~w_stall & (r_state != HALTED);
        if (w_load && !flush && haltIN) w_next = HALTED;
    end

    assign dmemREN   = w_req & dRENIN;
    assign dmemWEN   = w_req & dWENIN & ~dRENIN;
    assign dmemaddr  = resultIN;
    assign dmemstore = busBIN;
    assign mem_stall = w_stall;

    always_ff @(posedge CLK) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign stall_cnt = r_stall_cnt;

    memwb_reg u_memwb (
        .CLK         (CLK),
        .RST         (RST),
        .i_load      (w_load),
        .i_flush     (flush),
        .i_writeReg  (writeRegIN),
        .i_MemtoReg  (MemtoRegIN),
        .i_halt      (haltIN),
        .i_RWDSel    (RWDSelIN),
        .i_opcode    (opcodeIN),
        .i_PCInc     (PCIncIN),
        .i_result    (resultIN),
        .i_load_data (dmemload),
        .i_rw        (rwIN),
        .o_writeReg  (writeRegOUT),
        .o_MemtoReg  (MemtoRegOUT),
        .o_halt      (haltOUT),
        .o_RWDSel    (RWDSelOUT),
        .o_opcode    (opcodeOUT),
        .o_PCInc     (PCIncOUT),
        .o_result    (resultOUT),
        .o_load_data (loadOUT),
        .o_rw        (rwOUT)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hits, misses, flush, halt, reset and
// stall-counter saturation (counter narrowed to 3 bits).
module tb_mem_stage;
    import cpu_types_pkg::*;

    localparam int CW = 3;

    mem_if #(.STALL_CNT_W(CW)) mif ();

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.STALL_CNT_W(CW)) dut (
        .CLK         (mif.CLK),
        .RST         (mif.RST),
        .enable      (mif.enable),
        .flush       (mif.flush),
        .writeRegIN  (mif.writeRegIN),
        .MemtoRegIN  (mif.MemtoRegIN),
        .dRENIN      (mif.dRENIN),
        .dWENIN      (mif.dWENIN),
        .haltIN      (mif.haltIN),
        .RWDSelIN    (mif.RWDSelIN),
        .opcodeIN    (mif.opcodeIN),
        .PCIncIN     (mif.PCIncIN),
        .resultIN    (mif.resultIN),
        .busBIN      (mif.busBIN),
        .rwIN        (mif.rwIN),
        .dhit        (mif.dhit),
        .dmemload    (mif.dmemload),
        .dmemREN     (mif.dmemREN),
        .dmemWEN     (mif.dmemWEN),
        .dmemaddr    (mif.dmemaddr),
        .dmemstore   (mif.dmemstore),
        .writeRegOUT (mif.writeRegOUT),
        .MemtoRegOUT (mif.MemtoRegOUT),
        .haltOUT     (mif.haltOUT),
        .RWDSelOUT   (mif.RWDSelOUT),
        .opcodeOUT   (mif.opcodeOUT),
        .PCIncOUT    (mif.PCIncOUT),
        .resultOUT   (mif.resultOUT),
        .loadOUT     (mif.loadOUT),
        .rwOUT       (mif.rwOUT),
        .mem_stall   (mif.mem_stall),
        .stall_cnt   (mif.stall_cnt)
    );

    initial mif.CLK = 1'b0;
    always #5 mif.CLK = ~mif.CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mif.CLK);
        #1;
    endtask

    task automatic clear_inputs();
        mif.enable = 1'b1;      mif.flush = 1'b0;
        mif.writeRegIN = 1'b0;  mif.MemtoRegIN = 1'b0;
        mif.dRENIN = 1'b0;      mif.dWENIN = 1'b0;   mif.haltIN = 1'b0;
        mif.RWDSelIN = 2'd0;    mif.opcodeIN = RTYPE;
        mif.PCIncIN = '0;       mif.resultIN = '0;   mif.busBIN = '0;
        mif.rwIN = '0;          mif.dhit = 1'b0;     mif.dmemload = '0;
    endtask

    initial begin
        // Reset with busy inputs
        clear_inputs();
        mif.RST = 1'b1;
        mif.dRENIN = 1'b1; mif.haltIN = 1'b1; mif.writeRegIN = 1'b1;
        mif.resultIN = 32'h1234_5678; mif.rwIN = 5'd9; mif.dmemload = 32'hFFFF_FFFF;
        tick();
        check("rst_ren", {31'd0, mif.dmemREN}, 32'd0);
        check("rst_stall", {31'd0, mif.mem_stall}, 32'd0);
        tick();
        clear_inputs();
        mif.RST = 1'b0;
        #1;
        check("rst_wen", {31'd0, mif.dmemWEN}, 32'd0);
        check("rst_ren2", {31'd0, mif.dmemREN}, 32'd0);
        check("rst_halt", {31'd0, mif.haltOUT}, 32'd0);
        check("rst_wreg", {31'd0, mif.writeRegOUT}, 32'd0);
        check("rst_result", mif.resultOUT, 32'd0);
        check("rst_load", mif.loadOUT, 32'd0);
        check("rst_rw", {27'd0, mif.rwOUT}, 32'd0);
        check("rst_cnt", {29'd0, mif.stall_cnt}, 32'd0);

        // LW hit
        mif.dRENIN = 1'b1; mif.resultIN = 32'h100; mif.dhit = 1'b1;
        mif.dmemload = 32'hDEAD_BEEF; mif.rwIN = 5'd7; mif.writeRegIN = 1'b1;
        mif.MemtoRegIN = 1'b1; mif.opcodeIN = LW; mif.PCIncIN = 32'h404; mif.RWDSelIN = 2'd1;
        #1;
        check("lw_ren", {31'd0, mif.dmemREN}, 32'd1);
        check("lw_wen", {31'd0, mif.dmemWEN}, 32'd0);
        check("lw_addr", mif.dmemaddr, 32'h100);
        check("lw_stall", {31'd0, mif.mem_stall}, 32'd0);
        tick();
        check("lw_load", mif.loadOUT, 32'hDEAD_BEEF);
        check("lw_rw", {27'd0, mif.rwOUT}, 32'd7);
        check("lw_wreg", {31'd0, mif.writeRegOUT}, 32'd1);
        check("lw_m2r", {31'd0, mif.MemtoRegOUT}, 32'd1);
        check("lw_pc", mif.PCIncOUT, 32'h404);
        check("lw_rwd", {30'd0, mif.RWDSelOUT}, 32'd1);
        check("lw_op", {26'd0, mif.opcodeOUT}, {26'd0, LW});

        // Read and write together: only the read goes out
        mif.dWENIN = 1'b1; mif.resultIN = 32'h180;
        #1;
        check("rw_ren", {31'd0, mif.dmemREN}, 32'd1);
        check("rw_wen", {31'd0, mif.dmemWEN}, 32'd0);
        tick();
        check("rw_result", mif.resultOUT, 32'h180);

        // SW miss: 3 miss cycles then hit
        clear_inputs();
        mif.dWENIN = 1'b1; mif.resultIN = 32'h200; mif.busBIN = 32'h1234;
        mif.opcodeIN = SW; mif.dmemload = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sw_wen", {31'd0, mif.dmemWEN}, 32'd1);
            check("sw_store", mif.dmemstore, 32'h1234);
            check("sw_stall", {31'd0, mif.mem_stall}, 32'd1);
            tick();
            check("sw_hold", mif.resultOUT, 32'h180);
        end
        mif.dhit = 1'b1;
        #1;
        check("sw_wen_hit", {31'd0, mif.dmemWEN}, 32'd1);
        check("sw_addr_hit", mif.dmemaddr, 32'h200);
        check("sw_stall_hit", {31'd0, mif.mem_stall}, 32'd0);
        tick();
        check("sw_result", mif.resultOUT, 32'h200);
        check("sw_cnt", {29'd0, mif.stall_cnt}, 32'd3);

        // ALU pass-through and enable hold
        clear_inputs();
        mif.resultIN = 32'h55; mif.writeRegIN = 1'b1; mif.rwIN = 5'd3;
        #1;
        check("alu_ren", {31'd0, mif.dmemREN}, 32'd0);
        check("alu_wen", {31'd0, mif.dmemWEN}, 32'd0);
        check("alu_stall", {31'd0, mif.mem_stall}, 32'd0);
        tick();
        check("alu_result", mif.resultOUT, 32'h55);
        check("alu_rw", {27'd0, mif.rwOUT}, 32'd3);
        mif.enable = 1'b0; mif.resultIN = 32'h66; mif.rwIN = 5'd4;
        tick();
        check("en0_result", mif.resultOUT, 32'h55);
        check("en0_rw", {27'd0, mif.rwOUT}, 32'd3);
        mif.enable = 1'b1;

        // Flush in IDLE
        mif.flush = 1'b1; mif.resultIN = 32'h77;
        tick();
        check("fl_wreg", {31'd0, mif.writeRegOUT}, 32'd0);
        check("fl_result", mif.resultOUT, 32'd0);

        mif.flush = 1'b0; mif.resultIN = 32'h88;
        tick();
        check("pre_wreg", {31'd0, mif.writeRegOUT}, 32'd1);

        // Flush held during a 2-cycle read miss
        mif.dRENIN = 1'b1; mif.resultIN = 32'h300; mif.flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("flw_ren", {31'd0, mif.dmemREN}, 32'd1);
            check("flw_stall", {31'd0, mif.mem_stall}, 32'd1);
            tick();
            check("flw_hold", mif.resultOUT, 32'h88);
            check("flw_wreg", {31'd0, mif.writeRegOUT}, 32'd1);
        end
        mif.dhit = 1'b1;
        tick();
        check("flw_bubble", {31'd0, mif.writeRegOUT}, 32'd0);
        check("flw_result", mif.resultOUT, 32'd0);
        check("flw_cnt", {29'd0, mif.stall_cnt}, 32'd5);

        // Counter saturation: three more miss cycles from 5
        clear_inputs();
        mif.dRENIN = 1'b1; mif.resultIN = 32'h400;
        tick(); tick(); tick();
        check("sat_cnt", {29'd0, mif.stall_cnt}, 32'd7);
        mif.dhit = 1'b1;
        tick();
        check("sat_cnt2", {29'd0, mif.stall_cnt}, 32'd7);
        check("sat_result", mif.resultOUT, 32'h400);

        // Halt is sticky
        clear_inputs();
        mif.haltIN = 1'b1; mif.resultIN = 32'h99;
        tick();
        check("halt_out", {31'd0, mif.haltOUT}, 32'd1);
        check("halt_result", mif.resultOUT, 32'h99);
        mif.haltIN = 1'b0; mif.dRENIN = 1'b1; mif.resultIN = 32'hAA;
        #1;
        check("halt_ren", {31'd0, mif.dmemREN}, 32'd0);
        check("halt_stall", {31'd0, mif.mem_stall}, 32'd0);
        tick();
        check("halt_hold", mif.resultOUT, 32'h99);
        check("halt_sticky", {31'd0, mif.haltOUT}, 32'd1);
        mif.RST = 1'b1;
        tick();
        mif.RST = 1'b0;
        check("halt_rst", {31'd0, mif.haltOUT}, 32'd0);
        check("halt_rst_cnt", {29'd0, mif.stall_cnt}, 32'd0);

        // Reset in the middle of a miss
        clear_inputs();
        mif.dRENIN = 1'b1; mif.resultIN = 32'h500;
        #1;
        check("mw_stall", {31'd0, mif.mem_stall}, 32'd1);
        tick();
        check("mw_cnt", {29'd0, mif.stall_cnt}, 32'd1);
        mif.RST = 1'b1;
        tick();
        mif.RST = 1'b0;
        mif.dRENIN = 1'b0; mif.dhit = 1'b0;
        #1;
        check("mw_ren", {31'd0, mif.dmemREN}, 32'd0);
        check("mw_idle", {31'd0, mif.mem_stall}, 32'd0);
        check("mw_result", mif.resultOUT, 32'd0);
        check("mw_cnt0", {29'd0, mif.stall_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
